// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Purpose : Shared fetch-stage types and constants (width, NOP, reset PC).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0]     NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module  : fetch_unit_if
// Purpose : Instruction-memory, redirect and decode handshake bundle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if #(
  parameter int XLEN = 32
) ();

  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [31:0]     dec_inst;
  logic [XLEN-1:0] dec_pc;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output dec_valid,
    input  dec_ready,
    output dec_inst,
    output dec_pc
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  dec_valid,
    output dec_ready,
    input  dec_inst,
    input  dec_pc
  );

endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module  : fetch_fifo
// Purpose : Flushable fetch queue with a registered head; an entry becomes
//           visible the cycle after its push.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_flush,
  input  wire logic         i_push,
  input  wire fetch_entry_t i_push_data,
  input  wire logic         i_pop,
  output logic              o_head_valid,
  output fetch_entry_t      o_head,
  output logic [CW-1:0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_head_valid;
  fetch_entry_t  r_head;

  logic          w_pop;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_remaining;
  fetch_entry_t  w_head_nxt;

  assign w_pop = i_pop && r_head_valid;

  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
    w_remaining  = r_count - CW'(w_pop);
    w_count_nxt  = w_remaining + CW'(i_push);
    w_head_nxt   = r_head;
    // When nothing stays behind the head, the word being pushed becomes the head.
    if (w_count_nxt != '0) begin
      if (w_remaining == '0) begin
        w_head_nxt = i_push_data;
      end else begin
        w_head_nxt = r_mem[w_rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_head_valid <= 1'b0;
      r_head       <= '{pc: '0, inst: NOP_INST};
    end else if (i_flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_head_valid <= 1'b0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_count      <= w_count_nxt;
      r_head_valid <= (w_count_nxt != '0);
      r_head       <= w_head_nxt;
    end
  end

  assign o_head_valid = r_head_valid;
  assign o_head       = r_head;
  assign o_count      = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module  : fetch_unit
// Purpose : PC owner and instruction fetch stage feeding decode through a
//           small queue. Define FETCH_PERF_EN to add fetch/flush counters.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  wire logic    clk,
  input  wire logic    rst,
  fetch_unit_if.master io_fetch
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  fetch_count,
  output logic [15:0]  flush_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_inflight;

  logic            w_head_valid;
  fetch_entry_t    w_head;
  logic [CW-1:0]   w_count;
  logic            w_pop;
  logic [OW-1:0]   w_occupancy;
  logic            w_issue;
  fetch_entry_t    w_push_data;

  assign w_pop = w_head_valid && io_fetch.dec_ready;

  // Queue slots already claimed, counting the word still in the memory pipe.
  assign w_occupancy = OW'(w_count) + OW'(r_inflight) - OW'(w_pop);
  assign w_issue     = !rst && !io_fetch.redirect_valid && (w_occupancy < OW'(DEPTH));

  assign w_push_data = '{pc: r_req_pc, inst: io_fetch.imem_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
    end else if (io_fetch.redirect_valid) begin
      r_pc       <= word_align(io_fetch.redirect_pc);
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_req_pc <= r_pc;
        r_pc     <= r_pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (io_fetch.redirect_valid),
    .i_push       (r_inflight),
    .i_push_data  (w_push_data),
    .i_pop        (w_pop),
    .o_head_valid (w_head_valid),
    .o_head       (w_head),
    .o_count      (w_count)
  );

  assign io_fetch.imem_addr = r_pc;
  assign io_fetch.dec_valid = w_head_valid;
  assign io_fetch.dec_inst  = w_head.inst;
  assign io_fetch.dec_pc    = w_head.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_pop) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (io_fetch.redirect_valid) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign fetch_count = r_fetch_count;
  assign flush_count = r_flush_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module  : tb_fetch_unit
// Purpose : Directed plus randomized bench; the model tracks the expected
//           program-order PC stream that decode should see.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] SALT     = 32'hA5A5_0000;
  localparam logic [31:0] TB_RST_PC = 32'h0000_0000;

  logic clk;
  logic rst;

  fetch_unit_if #(.XLEN(32)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [15:0] flush_count;
`endif

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (TB_RST_PC),
    .DEPTH    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .io_fetch    (bus.master)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count (fetch_count),
    .flush_count (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered instruction memory: word depends only on the address.
  always @(posedge clk) bus.imem_rdata <= bus.imem_addr ^ SALT;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_pc;
  logic [31:0] last_pc;
  logic [31:0] last_inst;
  int unsigned n_hs;
  int unsigned n_flush;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Scores the handshake about to happen, then advances one clock.
  task automatic cycle();
    logic was_rst;
    was_rst = rst;
    if (!rst) begin
      if (bus.dec_valid && bus.dec_ready) begin
        check("hs_pc", 64'(bus.dec_pc), 64'(exp_pc));
        check("hs_inst", 64'(bus.dec_inst), 64'(exp_pc ^ SALT));
        exp_pc = exp_pc + 32'd4;
        n_hs++;
      end else if (!bus.dec_valid) begin
        check("hold_pc", 64'(bus.dec_pc), 64'(last_pc));
        check("hold_inst", 64'(bus.dec_inst), 64'(last_inst));
      end
      if (bus.dec_valid) begin
        last_pc   = bus.dec_pc;
        last_inst = bus.dec_inst;
      end
      if (bus.redirect_valid) begin
        exp_pc = bus.redirect_pc & ~32'd3;
        n_flush++;
      end
    end
    @(posedge clk);
    #1;
    if (was_rst) begin
      exp_pc    = TB_RST_PC;
      last_pc   = '0;
      last_inst = NOP_INST;
      n_hs      = 0;
      n_flush   = 0;
    end
`ifdef FETCH_PERF_EN
    check("fetch_count", 64'(fetch_count), 64'(n_hs));
    check("flush_count", 64'(flush_count), 64'(n_flush[15:0]));
`endif
  endtask

  task automatic pulse_reset(input logic ready);
    rst           = 1'b1;
    bus.dec_ready = ready;
    cycle();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    cycle();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    rst                = 1'b1;
    bus.dec_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    exp_pc             = TB_RST_PC;
    last_pc            = '0;
    last_inst          = NOP_INST;
    n_hs               = 0;
    n_flush            = 0;
    cycle();
    cycle();
    rst = 1'b0;

    check("rst_valid", 64'(bus.dec_valid), 64'(0));
    check("rst_inst", 64'(bus.dec_inst), 64'(NOP_INST));
    check("rst_pc", 64'(bus.dec_pc), 64'(0));
    check("rst_addr", 64'(bus.imem_addr), 64'(TB_RST_PC));

    // Streaming from reset: first word on cycle 2, then one per cycle.
    cycle();
    check("lat_c1_valid", 64'(bus.dec_valid), 64'(0));
    cycle();
    check("lat_c2_valid", 64'(bus.dec_valid), 64'(1));
    check("lat_c2_pc", 64'(bus.dec_pc), 64'(TB_RST_PC));
    for (int i = 0; i < 8; i++) begin
      check("stream_valid", 64'(bus.dec_valid), 64'(1));
      cycle();
    end

    // Backpressure: queue fills to two entries and the PC stops.
    pulse_reset(1'b0);
    for (int i = 0; i < 10; i++) cycle();
    check("full_valid", 64'(bus.dec_valid), 64'(1));
    check("full_head", 64'(bus.dec_pc), 64'(TB_RST_PC));
    check("full_addr", 64'(bus.imem_addr), 64'(TB_RST_PC + 32'd8));
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 64'(bus.dec_valid), 64'(1));
      cycle();
    end

    // Redirect while the queue holds a word and another is in flight.
    pulse_reset(1'b0);
    cycle();
    cycle();
    check("pre_redir_valid", 64'(bus.dec_valid), 64'(1));
    redirect(32'h0000_0103);
    bus.dec_ready = 1'b1;
    check("redir_r1_valid", 64'(bus.dec_valid), 64'(0));
    cycle();
    check("redir_r2_valid", 64'(bus.dec_valid), 64'(0));
    cycle();
    check("redir_r3_valid", 64'(bus.dec_valid), 64'(1));
    check("redir_r3_pc", 64'(bus.dec_pc), 64'(32'h0000_0100));
    cycle();
    check("redir_r4_pc", 64'(bus.dec_pc), 64'(32'h0000_0104));
    cycle();
    cycle();

    // Redirect coinciding with a pop, then a second redirect on an empty queue.
    check("pop_redir_valid", 64'(bus.dec_valid), 64'(1));
    redirect(32'h0000_0200);
    check("empty_redir_valid", 64'(bus.dec_valid), 64'(0));
    redirect(32'h0000_0301);
    check("er_r1_valid", 64'(bus.dec_valid), 64'(0));
    cycle();
    check("er_r2_valid", 64'(bus.dec_valid), 64'(0));
    cycle();
    check("er_r3_pc", 64'(bus.dec_pc), 64'(32'h0000_0300));
    cycle();
    cycle();

    // PC wrap at the top of the address space.
    redirect(32'hFFFF_FFF8);
    cycle();
    cycle();
    check("wrap_pc0", 64'(bus.dec_pc), 64'(32'hFFFF_FFF8));
    cycle();
    check("wrap_pc1", 64'(bus.dec_pc), 64'(32'hFFFF_FFFC));
    cycle();
    check("wrap_pc2", 64'(bus.dec_pc), 64'(32'h0000_0000));
    cycle();

    // Reset mid-stream while a request is in flight.
    pulse_reset(1'b1);
    check("midrst_valid", 64'(bus.dec_valid), 64'(0));
    cycle();
    check("midrst_c1_valid", 64'(bus.dec_valid), 64'(0));
    cycle();
    check("midrst_c2_pc", 64'(bus.dec_pc), 64'(TB_RST_PC));

    // Randomized traffic: backpressure, redirects and occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] r;
      r                  = $urandom;
      bus.dec_ready      = (r[1:0] != 2'b00);
      bus.redirect_valid = (r[9:4] < 6'd3);
      bus.redirect_pc    = $urandom;
      rst                = (r[17:10] == 8'd0);
      check("rand_align", 64'(bus.imem_addr[1:0]), 64'(0));
      cycle();
    end
    rst                = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.dec_ready      = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check("final_valid", 64'(bus.dec_valid), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
